chad_stack_cache: RTL and testbench

//  Next-generation data/return stack for the chad core. It replaces the fixed
//  on-chip stack with a DEPTH-cell circular cache that spills to, and fills

---
 rtl/chad_stack_cache.sv | 168 ++++++++++++++++
 tb/tb_chad_stack_cache.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/chad_stack_cache.sv
// Circular on-chip stack cache for the chad core; spills the bottom cell to, and
// refills it from, a backing RAM in the background and stalls the core only when it must.
module chad_stack_cache #(
    parameter int WIDTH   = 18,
    parameter int DEPTH   = 16,
    parameter int MAWIDTH = 10,
    parameter int HI      = 12,
    parameter int LO      = 4
) (
    input  logic               clk,
    input  logic               resetq,
    input  logic               hold_i,
    input  logic [1:0]         delta_i,
    input  logic               we_i,
    input  logic [WIDTH-1:0]   wd_i,
    output logic [WIDTH-1:0]   rd_o,
    output logic               stall_o,
    output logic [MAWIDTH:0]   depth_o,
    output logic               oflow_o,
    output logic               uflow_o,
    output logic               mem_req_o,
    output logic               mem_we_o,
    output logic [MAWIDTH-1:0] mem_addr_o,
    output logic [WIDTH-1:0]   mem_wdata_o,
    input  logic               mem_ack_i,
    input  logic [WIDTH-1:0]   mem_rdata_i
);
    // state | meaning
    // IDLE  | no backing RAM transfer outstanding
    // SPILL | bottom cell being written to RAM at mem_cnt; cell stays resident until ack
    // FILL  | RAM cell mem_cnt-1 being read into the slot below the bottom cell
    typedef enum logic [1:0] {S_IDLE, S_SPILL, S_FILL} state_t;

    localparam int PW = $clog2(DEPTH);
    localparam int NW = PW + 3;
    localparam logic signed [NW-1:0] N_DEPTH    = NW'(DEPTH);
    localparam logic signed [NW-1:0] N_DEPTH_M1 = NW'(DEPTH - 1);
    localparam logic signed [NW-1:0] N_ONE      = NW'(1);
    localparam logic [PW:0]          C_DEPTH    = (PW + 1)'(DEPTH);
    localparam logic [PW:0]          C_HI       = (PW + 1)'(HI);
    localparam logic [PW:0]          C_LO       = (PW + 1)'(LO);
    localparam logic [PW-1:0]        P_ONE      = PW'(1);
    localparam logic [MAWIDTH:0]     MEM_MAX    = {1'b1, {MAWIDTH{1'b0}}};
    localparam logic [MAWIDTH:0]     M_ONE      = (MAWIDTH + 1)'(1);
    localparam logic [MAWIDTH-1:0]   MA_ONE     = MAWIDTH'(1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   cell_q [DEPTH];
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [PW:0]        count_q, count_d;
    logic [MAWIDTH:0]   mem_cnt_q, mem_cnt_d;
    logic               mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [MAWIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic               oflow_q, oflow_d, uflow_q, uflow_d;

    logic signed [NW-1:0] delta_s, count_s, n, n_acc;
    logic [PW-1:0]        wr_idx, bottom;
    logic [MAWIDTH+1:0]   depth_sum;
    logic                 mem_full, mem_empty, stall_raw, cpu_go;
    logic                 spill_done, fill_done, over, under;

    always_comb begin
        delta_s    = {{(NW-2){delta_i[1]}}, delta_i};
        count_s    = {2'b00, count_q};
        n          = count_s + delta_s;
        mem_full   = (mem_cnt_q == MEM_MAX);
        mem_empty  = (mem_cnt_q == '0);
        // Outside IDLE the base rule still applies so a pending transfer is never raced.
        stall_raw  = ((n > N_DEPTH) && !mem_full) || (n[NW-1] && !mem_empty);
        if (state_q == S_SPILL) stall_raw = stall_raw || (n < N_ONE);
        if (state_q == S_FILL)  stall_raw = stall_raw || (n > N_DEPTH_M1);
        cpu_go     = !hold_i && !stall_raw;
        spill_done = mem_req_q && mem_ack_i && mem_we_q;
        fill_done  = mem_req_q && mem_ack_i && !mem_we_q;
        wr_idx     = ptr_q + delta_s[PW-1:0];
        bottom     = ptr_q - count_q[PW-1:0] + P_ONE;
        ptr_d      = cpu_go ? wr_idx : ptr_q;

        n_acc = cpu_go ? n : count_s;
        if (fill_done)  n_acc = n_acc + N_ONE;
        if (spill_done) n_acc = n_acc - N_ONE;
        // Only a full-RAM push or an empty-RAM pop can leave the range 0..DEPTH.
        over    = n_acc > N_DEPTH;
        under   = n_acc[NW-1];
        count_d = over ? C_DEPTH : (under ? '0 : n_acc[PW:0]);
        oflow_d = oflow_q || over;
        uflow_d = uflow_q || under;

        mem_cnt_d = mem_cnt_q;
        if (spill_done) mem_cnt_d = mem_cnt_q + M_ONE;
        if (fill_done)  mem_cnt_d = mem_cnt_q - M_ONE;

        depth_sum = {1'b0, mem_cnt_q} + (MAWIDTH + 2)'(count_q);
        depth_o   = depth_sum[MAWIDTH+1] ? '1 : depth_sum[MAWIDTH:0];
    end

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (count_q > C_HI && !mem_full) begin
                    state_d     = S_SPILL;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = mem_cnt_q[MAWIDTH-1:0];
                    mem_wdata_d = cell_q[bottom];
                end else if (count_q < C_LO && !mem_empty) begin
                    state_d    = S_FILL;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = mem_cnt_q[MAWIDTH-1:0] - MA_ONE;
                end
            end
            default: begin
                if (mem_ack_i) begin
                    state_d   = S_IDLE;
                    mem_req_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            count_q     <= '0;
            mem_cnt_q   <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            oflow_q     <= 1'b0;
            uflow_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            count_q     <= count_d;
            mem_cnt_q   <= mem_cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            oflow_q     <= oflow_d;
            uflow_q     <= uflow_d;
        end
    end

    // A CPU write to the same slot as a fill lands last: the filled cell became the top.
    always_ff @(posedge clk) begin
        if (fill_done)       cell_q[bottom - P_ONE] <= mem_rdata_i;
        if (cpu_go && we_i)  cell_q[wr_idx]         <= wd_i;
    end

    assign rd_o        = cell_q[ptr_q];
    assign stall_o     = resetq && stall_raw;
    assign oflow_o     = oflow_q;
    assign uflow_o     = uflow_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
endmodule

// File: tb/tb_chad_stack_cache.sv
// Scoreboard bench for chad_stack_cache: a queue-based logical stack model predicts
// every cycle's outputs; a monitor compares them against the DUT.
module tb_chad_stack_cache;
    localparam int WIDTH   = 18;
    localparam int DEPTH   = 16;
    localparam int MAWIDTH = 10;
    localparam int HI      = 12;
    localparam int LO      = 4;
    localparam int MEM_MAX = 1 << MAWIDTH;
    localparam int DEPTH_SAT = (1 << (MAWIDTH + 1)) - 1;

    logic               clk = 1'b0, resetq = 1'b0;
    logic               hold = 1'b0, we = 1'b0, mem_ack = 1'b0;
    logic [1:0]         delta = 2'b00;
    logic [WIDTH-1:0]   wd = '0, mem_rdata = '0;
    logic [WIDTH-1:0]   rd_o, mem_wdata_o;
    logic               stall_o, oflow_o, uflow_o, mem_req_o, mem_we_o;
    logic [MAWIDTH:0]   depth_o;
    logic [MAWIDTH-1:0] mem_addr_o;

    chad_stack_cache #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MAWIDTH(MAWIDTH), .HI(HI), .LO(LO)) dut (
        .clk(clk), .resetq(resetq), .hold_i(hold), .delta_i(delta), .we_i(we), .wd_i(wd),
        .rd_o(rd_o), .stall_o(stall_o), .depth_o(depth_o), .oflow_o(oflow_o), .uflow_o(uflow_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {logic [WIDTH-1:0] data; bit known;} elem_t;
    typedef struct {
        bit stall; bit rd_chk; logic [WIDTH-1:0] rd; int depth; bit oflow; bit uflow;
        bit req; bit mwe; int addr; bit wd_chk; logic [WIDTH-1:0] wdata;
    } exp_t;

    // Logical stack, bottom at index 0; the lowest m_mem entries live in backing RAM.
    elem_t            stk[$];
    exp_t             exp_q[$];
    exp_t             mon_e;
    logic [WIDTH-1:0] ram [MEM_MAX];
    int               m_mem, m_pend, lat_cnt, lat_sel;
    bit               m_oflow, m_uflow, m_stall;
    int               n_checks = 0, n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int dval(input logic [1:0] d);
        case (d)
            2'b01:   return 1;
            2'b11:   return -1;
            2'b10:   return -2;
            default: return 0;
        endcase
    endfunction

    function automatic int m_count();
        return stk.size() - m_mem;
    endfunction

    function automatic bit pred_stall(input int d);
        int n;
        bit s;
        n = m_count() + d;
        s = (n > DEPTH && m_mem < MEM_MAX) || (n < 0 && m_mem > 0);
        if (m_pend == 1) s = s || (n < 1);
        if (m_pend == 2) s = s || (n > DEPTH - 1);
        return s;
    endfunction

    task automatic model_reset();
        stk.delete();
        m_mem = 0; m_pend = 0; m_oflow = 0; m_uflow = 0; m_stall = 0;
    endtask

    task automatic push_exp();
        exp_t e;
        e.stall  = m_stall;
        e.rd_chk = (m_count() > 0) && stk[stk.size()-1].known;
        e.rd     = (stk.size() > 0) ? stk[stk.size()-1].data : '0;
        e.depth  = (stk.size() > DEPTH_SAT) ? DEPTH_SAT : stk.size();
        e.oflow  = m_oflow;
        e.uflow  = m_uflow;
        e.req    = (m_pend != 0);
        e.mwe    = (m_pend == 1);
        e.addr   = (m_pend == 1) ? m_mem : m_mem - 1;
        e.wd_chk = (m_pend == 1) && (m_mem < stk.size()) && stk[m_mem].known;
        e.wdata  = (m_pend == 1 && m_mem < stk.size()) ? stk[m_mem].data : '0;
        exp_q.push_back(e);
    endtask

    task automatic model_edge(input bit went, input int d, input bit w, input logic [WIDTH-1:0] data);
        int oc, om, start, n;
        oc = m_count(); om = m_mem; start = 0;
        if (m_pend == 0) begin
            if (oc > HI && om < MEM_MAX) start = 1;
            else if (oc < LO && om > 0) start = 2;
        end else if (mem_ack) begin
            m_mem  = m_mem + ((m_pend == 1) ? 1 : -1);
            m_pend = 0;
        end
        if (went) begin
            n = oc + d;
            if (d > 0) begin
                if (n > DEPTH) begin
                    stk.delete(m_mem);
                    m_oflow = 1;
                end
                stk.push_back('{w ? data : '0, w});
            end else if (d < 0) begin
                if (n < 0) begin
                    m_uflow = 1;
                    while (stk.size() > m_mem) void'(stk.pop_back());
                end else begin
                    repeat (-d) void'(stk.pop_back());
                end
            end
            if (w && d <= 0 && m_count() > 0) stk[stk.size()-1] = '{data, 1'b1};
        end
        if (start != 0) begin
            m_pend  = start;
            lat_cnt = (lat_sel >= 0) ? lat_sel : $urandom_range(0, 3);
        end
    endtask

    task automatic drive(input bit h, input logic [1:0] d, input bit w, input logic [WIDTH-1:0] data,
                         output bit went);
        @(negedge clk);
        hold = h; delta = d; we = w; wd = data;
        mem_ack = 1'b0;
        if (m_pend != 0) begin
            if (lat_cnt == 0) mem_ack = 1'b1;
            else lat_cnt--;
        end
        mem_rdata = (m_pend == 2) ? ram[m_mem-1] : WIDTH'($urandom);
        if (m_pend == 1 && mem_ack) ram[mem_addr_o] = mem_wdata_o;
        m_stall = pred_stall(dval(d));
        #1 push_exp();
        @(posedge clk);
        #1;
        went = !h && !m_stall;
        model_edge(went, dval(d), w, data);
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetq = 1'b0;
        mem_ack = 1'b0; hold = 1'b0; delta = 2'b00; we = 1'b0;
        model_reset();
        #1 push_exp();
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetq = 1'b1;
    endtask

    task automatic push_n(input int cnt, input int budget, input int base);
        int done, cyc;
        bit went;
        done = 0; cyc = 0;
        while (done < cnt && cyc < budget) begin
            drive(1'b0, 2'b01, 1'b1, (base >= 0) ? WIDTH'(base + done) : WIDTH'($urandom), went);
            if (went) done++;
            cyc++;
        end
        chk("push_budget", done, cnt);
    endtask

    task automatic pop_n(input int cnt, input int budget);
        int done, cyc;
        bit went;
        done = 0; cyc = 0;
        while (done < cnt && cyc < budget) begin
            drive(1'b0, 2'b11, 1'b0, '0, went);
            if (went) done++;
            cyc++;
        end
        chk("pop_budget", done, cnt);
    endtask

    task automatic idle_n(input int cyc);
        bit went;
        repeat (cyc) drive(1'b0, 2'b00, 1'b0, '0, went);
    endtask

    task automatic rand_ops(input int cyc, input int push_w);
        bit went;
        int r;
        logic [1:0] d;
        repeat (cyc) begin
            r = $urandom_range(0, 9);
            if (r < push_w) d = 2'b01;
            else if (r < 7) d = 2'b11;
            else if (r == 7) d = 2'b10;
            else d = 2'b00;
            drive($urandom_range(0, 9) == 0, d, $urandom_range(0, 3) != 0, WIDTH'($urandom), went);
        end
    endtask

    always @(negedge clk) begin
        #2;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("stall", stall_o, mon_e.stall);
            chk("depth", depth_o, mon_e.depth);
            chk("oflow", oflow_o, mon_e.oflow);
            chk("uflow", uflow_o, mon_e.uflow);
            chk("mem_req", mem_req_o, mon_e.req);
            if (mon_e.req) begin
                chk("mem_we", mem_we_o, mon_e.mwe);
                chk("mem_addr", mem_addr_o, mon_e.addr);
                if (mon_e.wd_chk) chk("mem_wdata", mem_wdata_o, mon_e.wdata);
            end
            if (mon_e.rd_chk) chk("rd", rd_o, mon_e.rd);
        end
    end

    initial begin
        int cyc;
        lat_sel = 1;
        model_reset();
        do_reset();
        // pushes 1..20 with a one-cycle RAM, then drain to empty and one pop past empty
        push_n(20, 200, 1);
        idle_n(12);
        pop_n(20, 400);
        idle_n(2);
        pop_n(1, 5);
        idle_n(2);
        // slow RAM: pushes stall against a long spill
        lat_sel = 10;
        push_n(24, 600, 100);
        idle_n(40);
        pop_n(22, 600);
        // mixed traffic with random latency, then drain
        lat_sel = -1;
        rand_ops(2500, 5);
        rand_ops(1000, 4);
        // fill RAM and cache completely, then overflow
        do_reset();
        lat_sel = 0;
        push_n(MEM_MAX + DEPTH, 5000, -1);
        idle_n(6);
        push_n(3, 10, -1);
        rand_ops(200, 3);
        // reset while a spill is outstanding
        do_reset();
        lat_sel = 6;
        push_n(14, 100, 500);
        cyc = 0;
        while (m_pend == 0 && cyc < 20) begin
            idle_n(1);
            cyc++;
        end
        chk("spill_started", m_pend, 1);
        do_reset();
        lat_sel = -1;
        push_n(5, 20, 700);
        rand_ops(500, 5);
        repeat (3) @(negedge clk);
        #3 chk("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
